microcode_sequencer: RTL and testbench

Parametrised successor to the CPU control unit. It generates the per-cycle control word from a step counter, using hardwired fetch steps followed by execute steps looked up in a writable microcode store indexed by {cf, zf, opcode, execute step}. It adds early end-of-instruction, halt/resume, clock-enable single-stepping and a microcode load port. It sits between the instruction register/flags and every datapath strobe.

---
 rtl/microcode_sequencer_pkg.sv | 35 +++
 rtl/microcode_sequencer_if.sv | 12 +
 rtl/microcode_sequencer_store.sv | 23 ++
 rtl/microcode_sequencer.sv | 107 ++++++++++
 tb/tb_microcode_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/microcode_sequencer_pkg.sv
// Global control-signal definitions shared by the sequencer, its store and anything
// that decodes the control word: strobe bit indices, fetch words, microcode fields.
package microcode_sequencer_pkg;

   localparam int CB_MAI = 0;
   localparam int CB_MO  = 1;
   localparam int CB_II  = 2;
   localparam int CB_PCS = 3;
   localparam int CB_PCO = 4;
   localparam int CB_OI  = 5;

   // END and HLT sit just above the ctrl bits: END = CTRL_W, HLT = CTRL_W+1
   localparam int UW_END_OFS = 0;
   localparam int UW_HLT_OFS = 1;

   localparam logic [15:0] F0 = 16'((1 << CB_PCO) | (1 << CB_MAI));
   localparam logic [15:0] F1 = 16'((1 << CB_MO) | (1 << CB_II) | (1 << CB_PCS));
   localparam logic [15:0] F2 = 16'((1 << CB_PCO) | (1 << CB_MAI));
   localparam logic [15:0] F3 = 16'((1 << CB_MO) | (1 << CB_OI) | (1 << CB_PCS));

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } seq_state_e;

   function automatic logic [15:0] fetch_word(input logic [1:0] idx);
      case (idx)
         2'd0:    return F0;
         2'd1:    return F1;
         2'd2:    return F2;
         default: return F3;
      endcase
   endfunction

endpackage

// File: rtl/microcode_sequencer_if.sv
// Microcode load port: the loader (master) writes words into the sequencer's store.
interface microcode_sequencer_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 18
);
   logic              ucode_we;
   logic [ADDR_W-1:0] ucode_addr;
   logic [DATA_W-1:0] ucode_data;

   modport master (output ucode_we, output ucode_addr, output ucode_data);
   modport slave  (input  ucode_we, input  ucode_addr, input  ucode_data);
endinterface

// File: rtl/microcode_sequencer_store.sv
// Writable microcode store: one synchronous write port, one combinational read port.
// Contents are deliberately untouched by reset so a loaded program survives it.
module microcode_sequencer_store #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 18
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/microcode_sequencer.sv
// Control-word sequencer: hardwired fetch steps, then execute steps read from the
// microcode store at {cf, zf, opcode, ustep}, with END/HLT, resume and en-freeze.
//
// state   | meaning
// ST_RUN  | stepping through fetch/execute when en=1, frozen when en=0
// ST_HALT | HLT seen; ctrl forced to 0, step held until resume or rst
module microcode_sequencer
   import microcode_sequencer_pkg::*;
#(
   parameter  int CTRL_W        = 16,
   parameter  int OPCODE_W      = 8,
   parameter  int STEP_W        = 3,
   parameter  int OPERAND_FETCH = 1,
   localparam int FETCH_STEPS   = (OPERAND_FETCH != 0) ? 4 : 2,
   localparam int CNT_W         = $clog2(FETCH_STEPS + 2**STEP_W),
   localparam int ADDR_W        = 2 + OPCODE_W + STEP_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_en,
   input  logic                i_resume,
   input  logic                i_zf,
   input  logic                i_cf,
   input  logic [OPCODE_W-1:0] i_ireg,
   output logic [CTRL_W-1:0]   o_ctrl,
   output logic [CNT_W-1:0]    o_step,
   output logic                o_halted,
   microcode_sequencer_if.slave ucode
);

   localparam logic [CNT_W-1:0] FETCH_CNT = CNT_W'(FETCH_STEPS);
   localparam int END_B = CTRL_W + UW_END_OFS;
   localparam int HLT_B = CTRL_W + UW_HLT_OFS;

   seq_state_e         r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_step, w_step_nxt;
   logic               w_is_fetch;
   logic [STEP_W-1:0]  w_ustep;
   logic [ADDR_W-1:0]  w_raddr;
   logic [CTRL_W+1:0]  w_store_word;
   logic [CTRL_W+1:0]  w_raw;

   assign w_is_fetch = (r_step < FETCH_CNT);
   assign w_ustep    = STEP_W'(r_step - FETCH_CNT);
   assign w_raddr    = {i_cf, i_zf, i_ireg, w_ustep};

   microcode_sequencer_store #(
      .ADDR_W (ADDR_W),
      .DATA_W (CTRL_W + 2)
   ) u_store (
      .clk     (clk),
      .i_we    (ucode.ucode_we),
      .i_waddr (ucode.ucode_addr),
      .i_wdata (ucode.ucode_data),
      .i_raddr (w_raddr),
      .o_rdata (w_store_word)
   );

   // Fetch steps come from constants and never carry END or HLT
   always_comb begin
      w_raw = w_store_word;
      if (w_is_fetch) w_raw = {2'b00, CTRL_W'(fetch_word(r_step[1:0]))};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RUN;
         r_step  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_step  <= w_step_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_step_nxt  = r_step;
      case (r_state)
         ST_HALT: begin
            if (i_resume) begin
               w_state_nxt = ST_RUN;
               w_step_nxt  = '0;
            end
         end
         ST_RUN: begin
            if (i_en) begin
               if (w_raw[HLT_B]) begin
                  w_state_nxt = ST_HALT;
               end else if (w_raw[END_B] || (!w_is_fetch && (w_ustep == '1))) begin
                  w_step_nxt = '0;
               end else begin
                  w_step_nxt = r_step + CNT_W'(1);
               end
            end
         end
      endcase
   end

   always_comb begin
      o_ctrl   = '0;
      o_halted = (r_state == ST_HALT);
      if (i_en && (r_state == ST_RUN)) o_ctrl = w_raw[CTRL_W-1:0];
   end

   assign o_step = r_step;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a behavioural model.
module tb_microcode_sequencer;

   logic        clk = 1'b0;
   logic        rst, en, resume, zf, cf;
   logic [7:0]  ireg;
   logic [15:0] ctrl;
   logic [3:0]  step;
   logic        halted;

   int total = 0;
   int bad   = 0;

   logic [15:0] fetch_tbl [4] = '{16'h0011, 16'h000E, 16'h0011, 16'h002A};
   logic [7:0]  pool [8]      = '{8'h00, 8'h05, 8'h07, 8'h0F, 8'h20, 8'h33, 8'hA5, 8'hFF};

   // behavioural model: step index, halt flag, and a copy of the store
   logic [17:0] m_mem [8192];
   int          m_step;
   bit          m_halt;
   bit          m_valid = 1'b0;

   microcode_sequencer_if #(.ADDR_W(13), .DATA_W(18)) uif ();

   microcode_sequencer #(
      .CTRL_W(16), .OPCODE_W(8), .STEP_W(3), .OPERAND_FETCH(1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .i_en     (en),
      .i_resume (resume),
      .i_zf     (zf),
      .i_cf     (cf),
      .i_ireg   (ireg),
      .o_ctrl   (ctrl),
      .o_step   (step),
      .o_halted (halted),
      .ucode    (uif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [17:0] model_word(int s);
      if (s < 4) return {2'b00, fetch_tbl[s]};
      return m_mem[{cf, zf, ireg, 3'(s - 4)}];
   endfunction

   initial begin
      for (int i = 0; i < 8192; i++) m_mem[i] = '0;
   end

   always @(posedge clk) begin
      logic [17:0] w;
      if (rst) begin
         m_step  = 0;
         m_halt  = 1'b0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         if (m_halt) begin
            if (resume) begin
               m_halt = 1'b0;
               m_step = 0;
            end
         end else if (en) begin
            w = model_word(m_step);
            if (w[17])                     m_halt = 1'b1;
            else if (w[16] || m_step == 11) m_step = 0;
            else                           m_step = m_step + 1;
         end
      end
      if (uif.ucode_we) m_mem[uif.ucode_addr] = uif.ucode_data;
   end

   always @(negedge clk) begin
      logic [17:0] w;
      if (m_valid) begin
         w = model_word(m_step);
         chk("model_ctrl", 32'(ctrl), 32'((en && !m_halt) ? w[15:0] : 16'h0));
         chk("model_step", 32'(step), 32'(m_step));
         chk("model_halted", 32'(halted), 32'(m_halt));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [12:0] a, input logic [17:0] d);
      uif.ucode_we   = 1'b1;
      uif.ucode_addr = a;
      uif.ucode_data = d;
      tick();
      uif.ucode_we   = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; resume = 1'b0; zf = 1'b0; cf = 1'b0; ireg = 8'h00;
      uif.ucode_we = 1'b0; uif.ucode_addr = '0; uif.ucode_data = '0;
      tick();

      // clear every word the bench will ever read, while held in reset
      for (int p = 0; p < 8; p++)
         for (int f = 0; f < 4; f++)
            for (int s = 0; s < 8; s++)
               wr({2'(f), pool[p], 3'(s)}, 18'h0);

      // empty store: four fetch words, eight zero execute steps, wrap at 12
      rst = 1'b0; ireg = 8'h00;
      #1;
      chk("rst_halted", 32'(halted), 32'd0);
      for (int c = 0; c < 12; c++) begin
         chk("blank_step", 32'(step), 32'(c));
         chk("blank_ctrl", 32'(ctrl), 32'((c < 4) ? fetch_tbl[c] : 16'h0));
         tick();
      end
      chk("blank_wrap", 32'(step), 32'd0);

      // END on first execute step
      rst = 1'b1;
      wr({2'b00, 8'h05, 3'd0}, 18'h10041);
      rst = 1'b0; ireg = 8'h05;
      repeat (4) tick();
      chk("end_ctrl", 32'(ctrl), 32'h0041);
      tick();
      chk("end_step", 32'(step), 32'd0);
      chk("end_ctrl_f0", 32'(ctrl), 32'h0011);

      // flag-dependent lookup
      rst = 1'b1;
      wr({2'b01, 8'h07, 3'd1}, 18'h01234);
      wr({2'b00, 8'h07, 3'd1}, 18'h04321);
      rst = 1'b0; ireg = 8'h07; zf = 1'b1;
      repeat (5) tick();
      chk("zf1_ctrl", 32'(ctrl), 32'h1234);
      zf = 1'b0;
      #1;
      chk("zf0_ctrl", 32'(ctrl), 32'h4321);

      // HLT then resume
      rst = 1'b1;
      wr({2'b00, 8'h0F, 3'd0}, 18'h20080);
      rst = 1'b0; ireg = 8'h0F;
      repeat (4) tick();
      chk("hlt_ctrl", 32'(ctrl), 32'h0080);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("halt_flag", 32'(halted), 32'd1);
         chk("halt_ctrl", 32'(ctrl), 32'h0);
         chk("halt_step", 32'(step), 32'd4);
      end
      resume = 1'b1;
      tick();
      resume = 1'b0;
      chk("resume_halted", 32'(halted), 32'd0);
      chk("resume_step", 32'(step), 32'd0);
      chk("resume_ctrl", 32'(ctrl), 32'h0011);

      // en freeze at step 2
      repeat (2) tick();
      en = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("frz_ctrl", 32'(ctrl), 32'h0);
         chk("frz_step", 32'(step), 32'd2);
         tick();
      end
      en = 1'b1;
      #1;
      chk("unfrz_f2", 32'(ctrl), 32'h0011);
      tick();
      chk("unfrz_f3", 32'(ctrl), 32'h002A);

      // reset while halted at step 6, store survives
      rst = 1'b1;
      wr({2'b00, 8'h20, 3'd0}, 18'h00101);
      wr({2'b00, 8'h20, 3'd2}, 18'h20F0F);
      rst = 1'b0; ireg = 8'h20;
      repeat (4) tick();
      chk("s6_ctrl4", 32'(ctrl), 32'h0101);
      repeat (2) tick();
      chk("s6_hlt_ctrl", 32'(ctrl), 32'h0F0F);
      tick();
      chk("s6_halted", 32'(halted), 32'd1);
      chk("s6_step", 32'(step), 32'd6);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("s6_rst_step", 32'(step), 32'd0);
      chk("s6_rst_halted", 32'(halted), 32'd0);
      repeat (4) tick();
      chk("s6_retained", 32'(ctrl), 32'h0101);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst    = ($urandom_range(0, 99) == 0);
         en     = ($urandom_range(0, 9) != 0);
         resume = ($urandom_range(0, 9) == 0);
         zf     = 1'($urandom_range(0, 1));
         cf     = 1'($urandom_range(0, 1));
         ireg   = pool[$urandom_range(0, 7)];
         uif.ucode_we   = ($urandom_range(0, 5) == 0);
         uif.ucode_addr = {2'($urandom_range(0, 3)), pool[$urandom_range(0, 7)],
                           3'($urandom_range(0, 7))};
         uif.ucode_data = {($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                           16'($urandom)};
         tick();
      end
      uif.ucode_we = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
